tlp_ocp_sequencer: RTL

Sequences PCIe memory-request TLPs from the RX header/payload FIFO (64-bit AXI-stream, Xilinx 64-bit TLP layout) into OCP 2.2 master transactions.
- Decodes the 3DW/4DW header, issues one OCP burst command per TLP, then streams write payload one DW per OCP data phase.
- Sits between the AXI FIFO master port and the axi2ocp OCP interface.
- Unsupported or malformed TLPs are drained and flagged.

---
 rtl/tlp_ocp_sequencer_if.sv | 31 +++
 rtl/tlp_ocp_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tlp_ocp_sequencer_if.sv
// AXI-stream TLP input and OCP 2.2 master command/data signals of the TLP-to-OCP sequencer.
// The sequencer connects through the master modport; the FIFO/OCP environment uses the slave modport.
interface tlp_ocp_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [63:0]       s_axis_tdata;
    logic [7:0]        s_axis_tkeep;
    logic              s_axis_tlast;
    logic [2:0]        MCmd;
    logic [ADDR_W-1:0] MAddr;
    logic [9:0]        MBurstLength;
    logic [2:0]        MBurstSeq;
    logic              MBurstSingleReq;
    logic [DATA_W-1:0] MData;
    logic              MDataValid;
    logic              SCmdAccept;
    logic              SDataAccept;

    modport master (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, SCmdAccept, SDataAccept,
        output s_axis_tready, MCmd, MAddr, MBurstLength, MBurstSeq, MBurstSingleReq, MData, MDataValid
    );

    modport slave (
        output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast, SCmdAccept, SDataAccept,
        input  s_axis_tready, MCmd, MAddr, MBurstLength, MBurstSeq, MBurstSingleReq, MData, MDataValid
    );
endinterface

// File: rtl/tlp_ocp_sequencer.sv
// Sequences PCIe memory-request TLPs (64-bit AXIS, Xilinx layout) into OCP burst transactions.
// Optional macro LEN_CHECK_EN: checks payload length against tlast/tkeep and adds sticky len_err.
module tlp_ocp_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                aresetn,
    tlp_ocp_sequencer_if.master bus,
    output logic                unsup_pulse,
`ifdef LEN_CHECK_EN
    output logic                len_err,
`endif
    output logic                busy
);
    // state | meaning
    // IDLE  | ready for header beat0 (DW0/DW1)
    // HDR1  | decode beat1, latch address, pop it unless it carries MWr32 payload
    // CMD   | OCP command presented until SCmdAccept
    // WDATA | one write DW per accepted OCP data phase
    // DROP  | drain unsupported/malformed TLP through tlast
    typedef enum logic [2:0] {ST_IDLE, ST_HDR1, ST_CMD, ST_WDATA, ST_DROP} state_t;

    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;

    state_t            state;
    logic [1:0]        fmt_q;
    logic [4:0]        type_q;
    logic [9:0]        len_q;
    logic              tready_q;
    logic              dw_sel;
    logic [10:0]       remaining;
    logic [2:0]        mcmd_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [9:0]        mblen_q;

    logic              pad;
    logic              beat_ends;
    logic              is_4dw, is_wr;
    logic [31:0]       lo_dw, hi_dw, addr_dw;
    logic [DATA_W-1:0] sel_dw;
    logic              beat_hs, last_dw, d_valid, d_hs, wr_pop, hdr_bad;
    logic              unused_ok;

`ifdef LEN_CHECK_EN
    // A tlast beat whose upper DW is not kept ends the payload on the lower DW.
    assign beat_ends = bus.s_axis_tlast && (bus.s_axis_tkeep[7:4] == 4'd0);
`else
    assign pad       = 1'b0;
    assign beat_ends = 1'b0;
`endif

    assign lo_dw   = bus.s_axis_tdata[31:0];
    assign hi_dw   = bus.s_axis_tdata[63:32];
    assign is_4dw  = fmt_q[0];
    assign is_wr   = fmt_q[1];
    assign addr_dw = is_4dw ? hi_dw : lo_dw;
    assign sel_dw  = dw_sel ? hi_dw : lo_dw;
    assign hdr_bad = (is_4dw && (lo_dw != 32'd0)) || (is_wr ? (is_4dw && bus.s_axis_tlast) : !bus.s_axis_tlast);

    assign beat_hs = bus.s_axis_tvalid && bus.s_axis_tready;
    assign last_dw = (remaining == 11'd1);
    assign d_valid = (state == ST_WDATA) && (pad || bus.s_axis_tvalid);
    assign d_hs    = d_valid && bus.SDataAccept;
    assign wr_pop  = d_hs && !pad && (dw_sel || last_dw || beat_ends);

    assign bus.s_axis_tready   = (state == ST_WDATA) ? wr_pop : tready_q;
    assign bus.MCmd            = mcmd_q;
    assign bus.MAddr           = maddr_q;
    assign bus.MBurstLength    = mblen_q;
    assign bus.MBurstSeq       = 3'b000;
    assign bus.MBurstSingleReq = (mcmd_q != CMD_IDLE);
    assign bus.MData           = (d_valid && !pad) ? sel_dw : '0;
    assign bus.MDataValid      = d_valid;
    assign busy                = (state != ST_IDLE);
    assign unused_ok           = ^bus.s_axis_tkeep;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            fmt_q       <= '0;
            type_q      <= '0;
            len_q       <= '0;
            tready_q    <= 1'b0;
            dw_sel      <= 1'b0;
            remaining   <= '0;
            mcmd_q      <= CMD_IDLE;
            maddr_q     <= '0;
            mblen_q     <= '0;
            unsup_pulse <= 1'b0;
`ifdef LEN_CHECK_EN
            pad         <= 1'b0;
            len_err     <= 1'b0;
`endif
        end else begin
            unsup_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tready_q <= 1'b1;
                    if (beat_hs) begin
                        fmt_q  <= lo_dw[30:29];
                        type_q <= lo_dw[28:24];
                        len_q  <= lo_dw[9:0];
                        if (bus.s_axis_tlast) begin
                            unsup_pulse <= 1'b1;
                        end else begin
                            state    <= ST_HDR1;
                            // MWr32 keeps beat1 (its upper DW is payload); unsupported types leave it for DROP
                            tready_q <= (lo_dw[28:24] == 5'd0) && (lo_dw[30:29] != 2'b10);
                        end
                    end
                end
                ST_HDR1: begin
                    if (type_q != 5'd0) begin
                        state       <= ST_DROP;
                        tready_q    <= 1'b1;
                        unsup_pulse <= 1'b1;
                    end else if (bus.s_axis_tvalid) begin
                        if (hdr_bad) begin
                            unsup_pulse <= 1'b1;
                            tready_q    <= 1'b1;
                            state       <= bus.s_axis_tlast ? ST_IDLE : ST_DROP;
                        end else begin
                            state     <= ST_CMD;
                            tready_q  <= 1'b0;
                            mcmd_q    <= is_wr ? CMD_WR : CMD_RD;
                            maddr_q   <= {addr_dw[ADDR_W-1:2], 2'b00};
                            mblen_q   <= len_q;
                            remaining <= {(len_q == 10'd0), len_q};
                            dw_sel    <= !is_4dw;
                        end
                    end
                end
                ST_CMD: begin
                    if (bus.SCmdAccept) begin
                        mcmd_q <= CMD_IDLE;
                        if (mcmd_q == CMD_WR) begin
                            state <= ST_WDATA;
                        end else begin
                            state    <= ST_IDLE;
                            tready_q <= 1'b1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (d_hs) begin
                        remaining <= remaining - 11'd1;
                        dw_sel    <= !dw_sel;
                        if (last_dw) begin
                            tready_q <= 1'b1;
`ifdef LEN_CHECK_EN
                            pad <= 1'b0;
                            if (!pad && !bus.s_axis_tlast) begin
                                state       <= ST_DROP;
                                len_err     <= 1'b1;
                                unsup_pulse <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else if (wr_pop && bus.s_axis_tlast) begin
                            pad     <= 1'b1;
                            len_err <= 1'b1;
`else
                            state <= ST_IDLE;
`endif
                        end
                    end
                end
                ST_DROP: begin
                    tready_q <= 1'b1;
                    if (beat_hs && bus.s_axis_tlast) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
